jtkcpu_simctl: RTL and testbench

Synthesizable bus-side companion for the jtkcpu core in the CPU-level simulation top: it consumes the core's memory bus (address, write data, write enable) and produces its read data and interrupt inputs. It contains 4 KB of work RAM, the simulation control register, a finish countdown and a programmable one-shot IRQ timer. ROM stays external and is reached through a dedicated read port. This moves memory decode and simulation control out of the bench into RTL, with single-strobe writes.

---
 rtl/jtkcpu_simctl.sv | 186 ++++++++++++++++++
 tb/tb_jtkcpu_simctl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_simctl.sv
// jtkcpu_simctl: bus-side companion for the jtkcpu core in CPU-level simulation.
// It holds the work RAM, the simulation control register, a finish countdown
// and a one-shot IRQ timer. ROM is external and reached through rom_addr/rom_data.
//
// Ports:
//   rst        synchronous active-high reset
//   clk        single clock
//   cen        CPU clock enable, ticks the IRQ timer
//   cen2       half-rate enable, qualifies CPU writes (one update per write)
//   addr       24-bit CPU address; [15:0] is decoded, [23:16] readable at 1??1
//   cpu_dout   CPU write data
//   we         CPU write enable
//   cpu_din    read data to CPU, combinational from addr/rom_data
//   rom_addr   external ROM address (addr[AW-1:0])
//   rom_data   external ROM data, combinational
//   nmi_n, firq_n, irq_n   active-low interrupt lines
//   done       sticky simulation-finished flag
//   pass       good flag captured when done rises
module jtkcpu_simctl #(
    parameter int AW         = 12,
    parameter int FINISH_DLY = 20
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          cen2,
    input  logic [23:0]   addr,
    input  logic [7:0]    cpu_dout,
    input  logic          we,
    output logic [7:0]    cpu_din,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic          nmi_n,
    output logic          firq_n,
    output logic          irq_n,
    output logic          done,
    output logic          pass
);

    localparam int CW = $clog2(FINISH_DLY) + 1;
    localparam logic [CW-1:0] FIN_LOAD = CW'(FINISH_DLY - 1);

    // Decoded address regions
    localparam logic [2:0] REG_NONE  = 3'd0;
    localparam logic [2:0] REG_RAM   = 3'd1;
    localparam logic [2:0] REG_CTRL  = 3'd2;
    localparam logic [2:0] REG_BANK  = 3'd3;
    localparam logic [2:0] REG_TIMER = 3'd4;
    localparam logic [2:0] REG_TCLR  = 3'd5;
    localparam logic [2:0] REG_ROM   = 3'd6;

    logic [7:0]    ram_r [0:(1<<AW)-1];
    logic [2:0]    region_s;
    logic          wr_s;
    logic [7:0]    ctrl_r,    ctrl_nxt_s;
    logic [7:0]    timer_r,   timer_nxt_s;
    logic          tirq_r,    tirq_nxt_s;
    logic [CW-1:0] fin_cnt_r, fin_cnt_nxt_s;
    logic          armed_r,   armed_nxt_s;
    logic          done_r,    done_nxt_s;
    logic          pass_r,    pass_nxt_s;
    logic          nmi_n_r, firq_n_r, irq_n_r;

    assign wr_s     = we & cen2;
    assign rom_addr = addr[AW-1:0];

    // Address decode on the low 16 bits
    always_comb begin
        region_s = REG_NONE;
        casez (addr[15:0])
            16'b0000_????_????_????: region_s = REG_RAM;
            16'b0001_????_????_0000: region_s = REG_CTRL;
            16'b0001_????_????_0001: region_s = REG_BANK;
            16'b0001_????_????_0010: region_s = REG_TIMER;
            16'b0001_????_????_0011: region_s = REG_TCLR;
            16'b1111_????_????_????: region_s = REG_ROM;
            default:                 region_s = REG_NONE;
        endcase
    end

    // Combinational read mux
    always_comb begin
        cpu_din = 8'h00;
        case (region_s)
            REG_RAM:   cpu_din = ram_r[addr[AW-1:0]];
            REG_CTRL:  cpu_din = {ctrl_r[7:1], 1'b0};
            REG_BANK:  cpu_din = addr[23:16];
            REG_TIMER: cpu_din = timer_r;
            REG_ROM:   cpu_din = rom_data;
            default:   cpu_din = 8'h00;
        endcase
    end

    // Work RAM write port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_s && region_s == REG_RAM) begin
            ram_r[addr[AW-1:0]] <= cpu_dout;
        end
    end

    // CTRL, timer and timer-IRQ next state; load beats expiry, expiry beats clear
    always_comb begin
        ctrl_nxt_s  = ctrl_r;
        timer_nxt_s = timer_r;
        tirq_nxt_s  = tirq_r;
        if (wr_s && region_s == REG_CTRL) begin
            ctrl_nxt_s = cpu_dout;
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        if (wr_s && region_s == REG_TIMER) begin
            timer_nxt_s = cpu_dout;
        end else if (cen && timer_r != 8'd0) begin
            timer_nxt_s = timer_r - 8'd1;
            if (timer_r == 8'd1) begin
                tirq_nxt_s = 1'b1;
            end else begin
                tirq_nxt_s = tirq_r;
            end
        end else begin
            timer_nxt_s = timer_r;
        end
        // A clear only lands when no expiry happened this cycle
        if (wr_s && region_s == REG_TCLR && !(tirq_nxt_s && !tirq_r)) begin
            tirq_nxt_s = 1'b0;
        end else begin
            tirq_nxt_s = tirq_nxt_s;
        end
    end

    // Finish countdown; a reload on the zero cycle keeps done low
    always_comb begin
        fin_cnt_nxt_s = fin_cnt_r;
        armed_nxt_s   = armed_r;
        done_nxt_s    = done_r;
        pass_nxt_s    = pass_r;
        if (wr_s && region_s == REG_CTRL && cpu_dout[0] && !done_r) begin
            fin_cnt_nxt_s = FIN_LOAD;
            armed_nxt_s   = 1'b1;
        end else if (armed_r) begin
            if (fin_cnt_r == {CW{1'b0}}) begin
                done_nxt_s  = 1'b1;
                pass_nxt_s  = ctrl_r[1];
                armed_nxt_s = 1'b0;
            end else begin
                fin_cnt_nxt_s = fin_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            fin_cnt_nxt_s = fin_cnt_r;
        end
    end

    // State registers; interrupt lines are registered from next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r    <= 8'h00;
            timer_r   <= 8'h00;
            tirq_r    <= 1'b0;
            fin_cnt_r <= {CW{1'b0}};
            armed_r   <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            nmi_n_r   <= 1'b1;
            firq_n_r  <= 1'b1;
            irq_n_r   <= 1'b1;
        end else begin
            ctrl_r    <= ctrl_nxt_s;
            timer_r   <= timer_nxt_s;
            tirq_r    <= tirq_nxt_s;
            fin_cnt_r <= fin_cnt_nxt_s;
            armed_r   <= armed_nxt_s;
            done_r    <= done_nxt_s;
            pass_r    <= pass_nxt_s;
            nmi_n_r   <= ~ctrl_nxt_s[7];
            firq_n_r  <= ~ctrl_nxt_s[6];
            irq_n_r   <= ~(ctrl_nxt_s[5] | tirq_nxt_s);
        end
    end

    assign nmi_n  = nmi_n_r;
    assign firq_n = firq_n_r;
    assign irq_n  = irq_n_r;
    assign done   = done_r;
    assign pass   = pass_r;

endmodule

// File: tb/tb_jtkcpu_simctl.sv
// Self-checking bench for jtkcpu_simctl: directed vectors, one task per feature.
module tb_jtkcpu_simctl;

    logic        rst, clk, cen, cen2, we;
    logic [23:0] addr;
    logic [7:0]  cpu_dout, cpu_din, rom_data;
    logic [11:0] rom_addr;
    logic        nmi_n, firq_n, irq_n, done, pass;

    int n_vec = 0;
    int n_err = 0;

    jtkcpu_simctl #(.AW(12), .FINISH_DLY(20)) dut (
        .rst(rst), .clk(clk), .cen(cen), .cen2(cen2), .addr(addr),
        .cpu_dout(cpu_dout), .we(we), .cpu_din(cpu_din), .rom_addr(rom_addr),
        .rom_data(rom_data), .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
        .done(done), .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks assume they start 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        addr = a; cpu_dout = d; we = 1'b1; cen2 = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; cen2 = 1'b0;
    endtask

    task automatic cen_pulse();
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a, input logic [7:0] exp, input string name);
        addr = a;
        #1;
        n_vec++;
        if (cpu_din !== exp) begin
            n_err++;
            $display("FAIL %s: cpu_din=%h expected %h", name, cpu_din, exp);
        end
    endtask

    task automatic chk(input logic got, input logic exp, input string name);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk(nmi_n, 1'b1, "reset nmi_n");
        chk(firq_n, 1'b1, "reset firq_n");
        chk(irq_n, 1'b1, "reset irq_n");
        chk(done, 1'b0, "reset done");
        chk(pass, 1'b0, "reset pass");
        rd(24'h001000, 8'h00, "reset ctrl");
        rd(24'h001002, 8'h00, "reset timer");
    endtask

    task automatic test_ram();
        wr(24'h000123, 8'h5A);
        rd(24'h000123, 8'h5A, "ram readback");
        rd(24'h7E1001, 8'h7E, "bank read");
        rd(24'h008000, 8'h00, "unmapped read");
        rd(24'h001003, 8'h00, "tclr read");
        rom_data = 8'hC3;
        rd(24'h00F010, 8'hC3, "rom read");
        n_vec++;
        if (rom_addr !== 12'h010) begin
            n_err++;
            $display("FAIL rom_addr: got %h expected %h", rom_addr, 12'h010);
        end
        rom_data = 8'h00;
    endtask

    task automatic test_ctrl();
        wr(24'h001000, 8'hE0);
        chk(nmi_n, 1'b0, "ctrl E0 nmi_n");
        chk(firq_n, 1'b0, "ctrl E0 firq_n");
        chk(irq_n, 1'b0, "ctrl E0 irq_n");
        rd(24'h001000, 8'hE0, "ctrl E0 read");
        wr(24'h001000, 8'h20);
        chk(nmi_n, 1'b1, "ctrl 20 nmi_n");
        chk(irq_n, 1'b0, "ctrl 20 irq_n");
        wr(24'h001000, 8'h00);
        chk(nmi_n, 1'b1, "ctrl 00 nmi_n");
        chk(firq_n, 1'b1, "ctrl 00 firq_n");
        chk(irq_n, 1'b1, "ctrl 00 irq_n");
    endtask

    // we held 4 clocks, cen2 only in the first: load 3 once, then 2 cen ticks -> 1
    task automatic test_strobe();
        addr = 24'h001002; cpu_dout = 8'h03; we = 1'b1; cen2 = 1'b1;
        tick(1);
        cen2 = 1'b0; cen = 1'b1;
        tick(2);
        cen = 1'b0;
        tick(1);
        we = 1'b0;
        rd(24'h001002, 8'h01, "strobe single load");
        chk(irq_n, 1'b1, "strobe no irq");
        wr(24'h001002, 8'h00);
    endtask

    task automatic test_timer();
        wr(24'h001002, 8'h05);
        rd(24'h001002, 8'h05, "timer load");
        repeat (4) cen_pulse();
        chk(irq_n, 1'b1, "timer before expiry");
        rd(24'h001002, 8'h01, "timer count 1");
        cen_pulse();
        chk(irq_n, 1'b0, "timer expiry irq_n");
        rd(24'h001002, 8'h00, "timer at 0");
        cen_pulse();
        rd(24'h001002, 8'h00, "timer stays 0");
        wr(24'h001003, 8'h55);
        chk(irq_n, 1'b1, "timer clear");
        wr(24'h001002, 8'h00);
        repeat (3) cen_pulse();
        chk(irq_n, 1'b1, "timer load 0 no irq");
    endtask

    task automatic test_simultaneous();
        wr(24'h001002, 8'h01);
        cen = 1'b1;
        wr(24'h001003, 8'h00);
        cen = 1'b0;
        chk(irq_n, 1'b0, "expiry beats clear");
        wr(24'h001003, 8'h00);
        chk(irq_n, 1'b1, "clear after expiry");
        wr(24'h001002, 8'h01);
        cen = 1'b1;
        wr(24'h001002, 8'h07);
        cen = 1'b0;
        rd(24'h001002, 8'h07, "load beats expiry count");
        chk(irq_n, 1'b1, "load beats expiry irq");
        wr(24'h001002, 8'h00);
    endtask

    task automatic test_finish();
        do_reset();
        wr(24'h001000, 8'h03);
        tick(19);
        chk(done, 1'b0, "finish good done early");
        tick(1);
        chk(done, 1'b1, "finish good done");
        chk(pass, 1'b1, "finish good pass");
        rd(24'h001000, 8'h02, "ctrl bit0 masked");
        wr(24'h001000, 8'h01);
        tick(25);
        chk(done, 1'b1, "done sticky");
        chk(pass, 1'b1, "pass unchanged after done");

        do_reset();
        wr(24'h001000, 8'h01);
        tick(19);
        chk(done, 1'b0, "finish bad done early");
        tick(1);
        chk(done, 1'b1, "finish bad done");
        chk(pass, 1'b0, "finish bad pass");

        do_reset();
        wr(24'h001000, 8'h03);
        tick(9);
        wr(24'h001000, 8'h03);
        tick(19);
        chk(done, 1'b0, "rewrite done at 29");
        tick(1);
        chk(done, 1'b1, "rewrite done at 30");

        do_reset();
        wr(24'h001000, 8'h03);
        tick(19);
        wr(24'h001000, 8'h03);
        chk(done, 1'b0, "reload at zero wins");
        tick(19);
        chk(done, 1'b0, "reload at zero early");
        tick(1);
        chk(done, 1'b1, "reload at zero done");
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        wr(24'h001002, 8'h04);
        wr(24'h001000, 8'h03);
        cen_pulse();
        cen_pulse();
        rst = 1'b1; cen = 1'b1;
        tick(1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (done !== 1'b0 || irq_n !== 1'b1) seen = 1'b1;
        end
        cen = 1'b0;
        chk(seen, 1'b0, "no event after reset");
        chk(done, 1'b0, "midreset done");
        chk(pass, 1'b0, "midreset pass");
        chk(nmi_n, 1'b1, "midreset nmi_n");
        chk(irq_n, 1'b1, "midreset irq_n");
        rd(24'h001002, 8'h00, "midreset timer");
        rd(24'h001000, 8'h00, "midreset ctrl");
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; cen2 = 1'b0; we = 1'b0;
        addr = 24'h000000; cpu_dout = 8'h00; rom_data = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_ram();
        test_ctrl();
        test_strobe();
        test_timer();
        test_simultaneous();
        test_finish();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
